// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the EX-stage ALU: operand forwarding,
// load-use hazard detection (stall + bubble) and flush handling.
module id_ex_stage #(
    parameter int bNUM = 32,
    parameter int bSEL = 4,
    parameter int bREG = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [bNUM-1:0] id_rs_data,
    input  logic [bNUM-1:0] id_rt_data,
    input  logic [bNUM-1:0] id_imm,
    input  logic [bREG-1:0] id_rs,
    input  logic [bREG-1:0] id_rt,
    input  logic [bREG-1:0] id_rd,
    input  logic [bSEL-1:0] id_alu_op,
    input  logic            id_alu_src,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_reg_write,
    input  logic            flush,
    input  logic            exmem_reg_write,
    input  logic [bREG-1:0] exmem_rd,
    input  logic [bNUM-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [bREG-1:0] memwb_rd,
    input  logic [bNUM-1:0] memwb_result,
    output logic [bNUM-1:0] A,
    output logic [bNUM-1:0] B,
    output logic [bSEL-1:0] Operation,
    output logic [bNUM-1:0] store_data,
    output logic            ex_valid,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic [bREG-1:0] ex_rd,
    output logic            stall
);

    localparam logic [bSEL-1:0] OP_ADD = bSEL'(2);

    logic [bNUM-1:0] ex_rs_data;
    logic [bNUM-1:0] ex_rt_data;
    logic [bNUM-1:0] ex_imm;
    logic [bREG-1:0] ex_rs;
    logic [bREG-1:0] ex_rt;
    logic [bSEL-1:0] ex_alu_op;
    logic            ex_alu_src;
    logic [bNUM-1:0] fwd_rs;
    logic [bNUM-1:0] fwd_rt;
    logic            rt_read;

    // rt is a real source for R-type ALU ops and for stores (store data).
    assign rt_read = !id_alu_src || id_mem_write;

    assign stall = !flush && id_valid && ex_valid && ex_mem_read && (ex_rd != '0)
                 && ((ex_rd == id_rs) || (rt_read && (ex_rd == id_rt)));

    // NOTE: state updates use non-blocking (<=) so every register samples the
    // pre-edge values; the async clear also makes stall drop the moment reset asserts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset || flush || stall) begin
            ex_valid     <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_rd        <= '0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_rs_data   <= '0;
            ex_rt_data   <= '0;
            ex_imm       <= '0;
            ex_alu_op    <= '0;
            ex_alu_src   <= 1'b0;
        end else begin
            ex_valid     <= id_valid;
            ex_mem_read  <= id_valid && id_mem_read;
            ex_mem_write <= id_valid && id_mem_write;
            ex_reg_write <= id_valid && id_reg_write;
            ex_rd        <= id_rd;
            ex_rs        <= id_rs;
            ex_rt        <= id_rt;
            ex_rs_data   <= id_rs_data;
            ex_rt_data   <= id_rt_data;
            ex_imm       <= id_imm;
            ex_alu_op    <= id_alu_op;
            ex_alu_src   <= id_alu_src;
        end
    end

    // EX/MEM is the newer producer, so it wins over MEM/WB; r0 never forwards.
    always_comb begin
        fwd_rs = ex_rs_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_rs))
            fwd_rs = exmem_result;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_rs))
            fwd_rs = memwb_result;

        fwd_rt = ex_rt_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_rt))
            fwd_rt = exmem_result;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_rt))
            fwd_rt = memwb_result;
    end

    // A bubble presents 0 + 0 to the ALU so its result is deterministic.
    assign A          = ex_valid ? fwd_rs : '0;
    assign B          = ex_valid ? (ex_alu_src ? ex_imm : fwd_rt) : '0;
    assign Operation  = ex_valid ? ex_alu_op : OP_ADD;
    assign store_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes reference-model predictions,
// an independent monitor pops and compares them against the DUT outputs.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic        alu_src;
        logic        mr;
        logic        mw;
        logic        rw;
    } instr_t;

    typedef struct packed {
        logic        xw;
        logic [4:0]  xrd;
        logic [31:0] xres;
        logic        ww;
        logic [4:0]  wrd;
        logic [31:0] wres;
    } fwd_t;

    typedef struct packed {
        logic        stall;
        logic        valid;
        logic        mr;
        logic        mw;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [3:0]  op;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        id_valid, id_alu_src, id_mem_read, id_mem_write, id_reg_write, flush;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [3:0]  id_alu_op;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] A, B, store_data;
    logic [3:0]  Operation;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, stall;
    logic [4:0]  ex_rd;

    int checks = 0;
    int failures = 0;
    exp_t   exp_q[$];
    instr_t model_ex = '0;   // instruction the model believes sits in EX

    id_ex_stage dut (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_write(id_reg_write), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .A(A), .B(B), .Operation(Operation), .store_data(store_data),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_rd(ex_rd), .stall(stall)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Value of a register as EX sees it: the newest in-flight writer wins.
    function automatic logic [31:0] reg_value(input logic [4:0] r, input logic [31:0] rf, input fwd_t f);
        if (r == 0) return rf;
        if (f.xw && f.xrd == r) return f.xres;
        if (f.ww && f.wrd == r) return f.wres;
        return rf;
    endfunction

    function automatic logic load_use(input instr_t id, input logic fl);
        logic uses_rt;
        uses_rt = !id.alu_src || id.mw;
        return !fl && id.valid && model_ex.valid && model_ex.mr && model_ex.rd != 0
               && (model_ex.rd == id.rs || (uses_rt && model_ex.rd == id.rt));
    endfunction

    function automatic instr_t mk(input logic [4:0] rs, input logic [31:0] rsd,
                                  input logic [4:0] rt, input logic [31:0] rtd,
                                  input logic [4:0] rd, input logic [3:0] op,
                                  input logic src, input logic [31:0] imm,
                                  input logic mr, input logic mw, input logic rw);
        instr_t i;
        i = '{valid: 1'b1, rs_data: rsd, rt_data: rtd, imm: imm, rs: rs, rt: rt, rd: rd,
              op: op, alu_src: src, mr: mr, mw: mw, rw: rw};
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.valid   = ($urandom_range(0, 9) != 0);
        i.rs_data = $urandom;
        i.rt_data = $urandom;
        i.imm     = $urandom;
        i.rs      = 5'($urandom_range(0, 3));
        i.rt      = 5'($urandom_range(0, 3));
        i.rd      = 5'($urandom_range(0, 3));
        i.op      = 4'($urandom);
        i.alu_src = 1'($urandom);
        i.mr      = ($urandom_range(0, 9) < 4);
        i.mw      = ($urandom_range(0, 9) < 2);
        i.rw      = 1'($urandom);
        return i;
    endfunction

    function automatic fwd_t rand_fwd();
        fwd_t f;
        f.xw   = 1'($urandom);
        f.xrd  = 5'($urandom_range(0, 3));
        f.xres = $urandom;
        f.ww   = 1'($urandom);
        f.wrd  = 5'($urandom_range(0, 3));
        f.wres = $urandom;
        return f;
    endfunction

    task automatic apply(input instr_t id, input logic fl, input fwd_t f);
        id_valid = id.valid;  id_rs_data = id.rs_data;  id_rt_data = id.rt_data;
        id_imm = id.imm;  id_rs = id.rs;  id_rt = id.rt;  id_rd = id.rd;
        id_alu_op = id.op;  id_alu_src = id.alu_src;  id_mem_read = id.mr;
        id_mem_write = id.mw;  id_reg_write = id.rw;  flush = fl;
        exmem_reg_write = f.xw;  exmem_rd = f.xrd;  exmem_result = f.xres;
        memwb_reg_write = f.ww;  memwb_rd = f.wrd;  memwb_result = f.wres;
    endtask

    // One ID cycle: drive inputs, advance the model, queue the expected response.
    task automatic drive(input instr_t id, input logic fl, input fwd_t f, output logic st);
        exp_t e;
        @(negedge clock);
        reset = 1'b1;
        apply(id, fl, f);
        st = load_use(id, fl);
        if (fl || st) model_ex = '0;
        else begin
            model_ex = id;
            if (!id.valid) begin
                model_ex.mr = 1'b0; model_ex.mw = 1'b0; model_ex.rw = 1'b0;
            end
        end
        e.stall = st;
        e.valid = model_ex.valid;
        e.mr    = model_ex.mr;
        e.mw    = model_ex.mw;
        e.rw    = model_ex.rw;
        e.rd    = model_ex.rd;
        e.sd    = reg_value(model_ex.rt, model_ex.rt_data, f);
        e.a     = model_ex.valid ? reg_value(model_ex.rs, model_ex.rs_data, f) : 32'd0;
        e.b     = !model_ex.valid ? 32'd0 : (model_ex.alu_src ? model_ex.imm : e.sd);
        e.op    = model_ex.valid ? model_ex.op : 4'b0010;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clock);
            n++;
        end
        #2;
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Monitor: stall is checked while ID is presented, EX outputs after the edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("stall", stall, e.stall);
                @(posedge clock);
                #1;
                check("ex_valid", ex_valid, e.valid);
                check("ex_mem_read", ex_mem_read, e.mr);
                check("ex_mem_write", ex_mem_write, e.mw);
                check("ex_reg_write", ex_reg_write, e.rw);
                check("A", A, e.a);
                check("B", B, e.b);
                check("Operation", Operation, e.op);
                if (e.valid) begin
                    check("ex_rd", ex_rd, e.rd);
                    check("store_data", store_data, e.sd);
                end
            end
        end
    end

    initial begin : stimulus
        instr_t idle, cur;
        fwd_t   nof, f;
        logic   st;
        idle = '0;
        nof  = '0;
        apply(idle, 1'b0, nof);

        #12;
        check("rst_A", A, 0);
        check("rst_B", B, 0);
        check("rst_Operation", Operation, 4'b0010);
        check("rst_store_data", store_data, 0);
        check("rst_ex_valid", ex_valid, 0);
        check("rst_ex_rd", ex_rd, 0);
        check("rst_stall", stall, 0);

        // Plain add, no hazards.
        drive(mk(1, 5, 2, 7, 4, 4'b0010, 0, 0, 0, 0, 1), 0, nof, st);

        // Forwarding priority and r0 exclusion on rs.
        f = '{xw: 1, xrd: 1, xres: 100, ww: 1, wrd: 1, wres: 200};
        drive(mk(1, 11, 2, 12, 5, 4'b0010, 0, 0, 0, 0, 1), 0, f, st);
        f.xw = 0;
        drive(mk(1, 11, 2, 12, 5, 4'b0010, 0, 0, 0, 0, 1), 0, f, st);
        f = '{xw: 1, xrd: 0, xres: 100, ww: 1, wrd: 0, wres: 200};
        drive(mk(0, 11, 0, 12, 5, 4'b0010, 0, 0, 0, 0, 1), 0, f, st);

        // Load-use: one stall cycle, a bubble, then the held add.
        drive(mk(0, 0, 0, 0, 3, 4'b0010, 1, 8, 1, 0, 1), 0, nof, st);
        drive(mk(3, 21, 2, 22, 6, 4'b0010, 0, 0, 0, 0, 1), 0, nof, st);
        drive(mk(3, 21, 2, 22, 6, 4'b0010, 0, 0, 0, 0, 1), 0, nof, st);

        // Immediate B: rt match alone does not stall.
        drive(mk(0, 0, 0, 0, 3, 4'b0010, 1, 8, 1, 0, 1), 0, nof, st);
        drive(mk(1, 31, 3, 32, 6, 4'b0010, 1, 40, 0, 0, 1), 0, nof, st);

        // Flush overrides the stall and discards the ID instruction.
        drive(mk(0, 0, 0, 0, 3, 4'b0010, 1, 8, 1, 0, 1), 0, nof, st);
        drive(mk(3, 41, 2, 42, 6, 4'b0110, 0, 0, 0, 0, 1), 1, nof, st);

        // Immediate operand with forwarded store data.
        f = '{xw: 1, xrd: 2, xres: 9, ww: 0, wrd: 0, wres: 0};
        drive(mk(1, 50, 2, 1, 0, 4'b0010, 1, 32'hFFFF_FFFC, 0, 1, 0), 0, f, st);

        // Randomised traffic; upstream holds ID while stalled.
        cur = rand_instr();
        for (int i = 0; i < 400; i++) begin
            drive(cur, ($urandom_range(0, 9) == 0), rand_fwd(), st);
            if (!st) cur = rand_instr();
        end
        drain();

        // Reset asserted mid-stall with a load in EX.
        drive(mk(0, 0, 0, 0, 3, 4'b0010, 1, 8, 1, 0, 1), 0, nof, st);
        drain();
        cur = mk(3, 61, 2, 62, 6, 4'b0010, 0, 0, 0, 0, 1);
        @(negedge clock);
        apply(cur, 1'b0, nof);
        #2;
        check("pre_reset_stall", stall, 1);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_stall", stall, 0);
        check("mid_rst_ex_valid", ex_valid, 0);
        check("mid_rst_A", A, 0);
        check("mid_rst_B", B, 0);
        check("mid_rst_Operation", Operation, 4'b0010);
        check("mid_rst_store_data", store_data, 0);
        @(posedge clock);
        #1;
        check("held_rst_ex_valid", ex_valid, 0);
        model_ex = '0;
        drive(mk(1, 71, 2, 72, 7, 4'b0001, 0, 0, 0, 0, 1), 0, nof, st);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the EX-stage ALU.
- Registers the decoded operands and control from ID, then drives the ALU A, B and Operation inputs through the forwarding muxes.
- Detects load-use hazards: stalls ID/IF and inserts a bubble into EX.
- Accepts a flush from branch/jump resolution.

Parameters:
bNUM, 32, datapath width (matches ALU bNUM)
bSEL, 4, ALU operation select width (matches ALU bSEL)
bREG, 5, register address width

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID holds a real instruction
id_rs_data, id_rt_data  in  bNUM  register file read data
id_imm  in  bNUM  sign/zero-extended immediate
id_rs, id_rt, id_rd  in  bREG  source/destination register addresses
id_alu_op  in  bSEL  ALU Operation code
id_alu_src  in  1  1 = B from immediate, 0 = B from rt
id_mem_read, id_mem_write, id_reg_write  in  1  control bits
flush  in  1  kill the instruction entering EX
exmem_reg_write  in  1  EX/MEM writes a register
exmem_rd  in  bREG  EX/MEM destination
exmem_result  in  bNUM  EX/MEM ALU result
memwb_reg_write  in  1  MEM/WB writes a register
memwb_rd  in  bREG  MEM/WB destination
memwb_result  in  bNUM  MEM/WB writeback data
A, B  out  bNUM  ALU operands
Operation  out  bSEL  ALU select
store_data  out  bNUM  forwarded rt value, for stores
ex_valid, ex_mem_read, ex_mem_write, ex_reg_write  out  1  registered control
ex_rd  out  bREG  registered destination
stall  out  1  hold PC and IF/ID this cycle

Behaviour:
- Reset (reset=0, async): all stage registers cleared, ex_valid=0, all control 0, ex_rd=0. Outputs while in reset: A=B=0, Operation=4'b0010, store_data=0, stall=0.
- Stall logic (combinational), stall=1 iff all of:
  - flush=0, id_valid=1, ex_valid=1, ex_mem_read=1, ex_rd!=0;
  - and either ex_rd==id_rs, or (id_alu_src=0 or id_mem_write=1) and ex_rd==id_rt.
- Rising edge, by priority:
  - flush=1: load a bubble (ex_valid, ex_mem_read, ex_mem_write, ex_reg_write = 0; data registers don't-care, cleared to 0).
  - else stall=1: load a bubble. ID content is not captured; upstream holds it.
  - else: capture all id_* fields; ex_valid<=id_valid. If id_valid=0, all control bits are captured as 0.
- Latency: one cycle from ID to the A/B/Operation outputs.
- Forwarding (combinational, on registered ex_rs/ex_rt), per source operand:
  - exmem_reg_write=1, exmem_rd!=0 and exmem_rd==ex_rs: forward exmem_result (priority, newest).
  - else memwb_reg_write=1, memwb_rd!=0 and memwb_rd==ex_rs: forward memwb_result.
  - else use ex_rs_data.
  - fwd_rt is built identically.
  - Register 0 is never forwarded.
- Output mapping:
  - A=fwd_rs.
  - B = ex_alu_src ? ex_imm : fwd_rt.
  - store_data=fwd_rt.
  - Operation=ex_alu_op.
- When ex_valid=0: A=B=0 and Operation=4'b0010 (ADD), so a bubble produces F=0 deterministically.
- Widths: all data paths bNUM, no extension inside this block.
- A stall lasts exactly one cycle per load: the bubble clears ex_mem_read, so stall deasserts the next cycle.
- Reset mid-stall: stall drops immediately with reset; the pipeline restarts from a bubble.

Test Plan:
- Reset asserted mid-operation with ex_valid=1 -> outputs immediately A=0, B=0, Operation=0010, ex_valid=0, stall=0; after release the first valid ID instruction appears at EX one edge later.
- ID add rs=1(data 5), rt=2(data 7), alu_op=0010, no hazards -> next cycle A=5, B=7, Operation=0010, ex_valid=1.
- EX/MEM rd=1 result=100 and MEM/WB rd=1 result=200, both reg_write=1, ex_rs=1 -> A=100; with exmem_reg_write=0 -> A=200; with exmem_rd=memwb_rd=0 -> A=ex_rs_data.
- Load lw rd=3 in EX (ex_mem_read=1), ID add rs=3 -> stall=1 for exactly 1 cycle, next EX is a bubble (ex_valid=0, A=B=0), add enters EX the cycle after; with id_alu_src=1 and ex_rd==id_rt only -> stall=0.
- flush=1 and stall condition in the same cycle -> stall=0, EX receives a bubble; ID instruction is not captured.
- addi rt path with id_alu_src=1, imm=0xFFFFFFFC and fwd_rt=9 -> B=0xFFFFFFFC, store_data=9.
